// File: rtl/approx_mult_err_eval_pkg.sv
// Shared types and width helpers for the approximate-multiplier error evaluator.
package approx_mult_err_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  function automatic int cnt_w(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int sum_w(input int n);
    return 4 * n;
  endfunction

  function automatic int bias_w(input int n);
    return 4 * n + 1;
  endfunction

endpackage

// File: rtl/approx_mult_err_eval_err_accum.sv
// Error metric datapath: stage 2 forms the signed error, stage 3 accumulates it.
module err_accum
  import approx_mult_err_eval_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                flush_i,
  input  logic                vld_i,
  input  logic [2*N-1:0]      prod_i,
  input  logic [2*N-1:0]      exact_i,
  output logic [2*N:0]        err_cnt_o,
  output logic [4*N-1:0]      sum_abs_err_o,
  output logic [2*N-1:0]      max_abs_err_o,
  output logic signed [4*N:0] bias_o
);

  localparam int PW = prod_w(N);
  localparam int CW = cnt_w(N);
  localparam int SW = sum_w(N);
  localparam int BW = bias_w(N);

  logic signed [PW:0]   diff_d, diff_q, neg_d;
  logic [PW-1:0]        abs_d, abs_q;
  logic                 nz_q, s2_vld_q;
  logic [CW-1:0]        cnt_q;
  logic [SW-1:0]        sum_q;
  logic [PW-1:0]        max_q;
  logic signed [BW-1:0] bias_q;

  // One extra bit holds the full signed range of product minus exact.
  always_comb begin
    diff_d = $signed({1'b0, prod_i}) - $signed({1'b0, exact_i});
    neg_d  = -diff_d;
    abs_d  = diff_d[PW] ? neg_d[PW-1:0] : diff_d[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      diff_q   <= '0;
      abs_q    <= '0;
      nz_q     <= 1'b0;
    end else begin
      s2_vld_q <= vld_i & ~flush_i & ~clr_i;
      if (vld_i) begin
        diff_q <= diff_d;
        abs_q  <= abs_d;
        nz_q   <= (diff_d != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      max_q  <= '0;
      bias_q <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      max_q  <= '0;
      bias_q <= '0;
    end else if (s2_vld_q && !flush_i) begin
      cnt_q  <= cnt_q + {{(CW-1){1'b0}}, nz_q};
      sum_q  <= sum_q + {{(SW-PW){1'b0}}, abs_q};
      bias_q <= bias_q + {{(BW-PW-1){diff_q[PW]}}, diff_q};
      if (abs_q > max_q) max_q <= abs_q;
    end
  end

  assign err_cnt_o     = cnt_q;
  assign sum_abs_err_o = sum_q;
  assign max_abs_err_o = max_q;
  assign bias_o        = bias_q;

endmodule

// File: rtl/approx_mult_err_eval.sv
// Exhaustive sweep controller: drives every operand pair into an external
// approximate multiplier and reports error metrics against the exact product.
module approx_mult_err_eval
  import approx_mult_err_eval_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [N-1:0]        op_a,
  output logic [N-1:0]        op_b,
  input  logic [2*N-1:0]      mult_r,
  output logic                busy,
  output logic                done,
  output logic [2*N:0]        err_cnt,
  output logic [4*N-1:0]      sum_abs_err,
  output logic [2*N-1:0]      max_abs_err,
  output logic signed [4*N:0] bias
);

  localparam int PW = prod_w(N);

  state_e        state_q, state_d;
  logic [PW-1:0] ops_q, ops_d;
  logic          drain_q, drain_d;
  logic          s1_vld_q, s1_vld_d;
  logic [PW-1:0] s1_prod_q, s1_exact_q, exact_w;
  logic          clr, flush;

  // op_a is the high half of the counter so op_b runs as the inner index.
  assign op_a    = ops_q[PW-1:N];
  assign op_b    = ops_q[N-1:0];
  assign exact_w = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
  assign busy    = (state_q == SWEEP) || (state_q == DRAIN);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    ops_d    = ops_q;
    drain_d  = drain_q;
    s1_vld_d = 1'b0;
    clr      = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          ops_d   = '0;
          clr     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
          ops_d   = '0;
          flush   = 1'b1;
        end else begin
          s1_vld_d = 1'b1;
          ops_d    = ops_q + 1'b1;
          if (&ops_q) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ops_q      <= '0;
      drain_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_prod_q  <= '0;
      s1_exact_q <= '0;
    end else begin
      state_q  <= state_d;
      ops_q    <= ops_d;
      drain_q  <= drain_d;
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) begin
        s1_prod_q  <= mult_r;
        s1_exact_q <= exact_w;
      end
    end
  end

  err_accum #(.N(N)) u_accum (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clr),
    .flush_i       (flush),
    .vld_i         (s1_vld_q),
    .prod_i        (s1_prod_q),
    .exact_i       (s1_exact_q),
    .err_cnt_o     (err_cnt),
    .sum_abs_err_o (sum_abs_err),
    .max_abs_err_o (max_abs_err),
    .bias_o        (bias)
  );

endmodule

// File: tb/tb_approx_mult_err_eval.sv
// Randomized self-checking bench: stand-in multipliers on mult_r, metrics checked
// against an all-pairs arithmetic reference.
module tb_approx_mult_err_eval;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst, start, abort;
  logic [N-1:0]       op_a, op_b;
  logic [2*N-1:0]     mult_r;
  logic               busy, done;
  logic [2*N:0]       err_cnt;
  logic [4*N-1:0]     sum_abs_err;
  logic [2*N-1:0]     max_abs_err;
  logic signed [4*N:0] bias;

  int         mode;
  logic [7:0] lut [256];
  int         n_cmp = 0;
  int         n_bad = 0;

  approx_mult_err_eval #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .mult_r(mult_r),
    .busy(busy), .done(done), .err_cnt(err_cnt),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .bias(bias)
  );

  always #5 clk = ~clk;

  // Multiplier under test: 0 exact, 1 tied low, 2 exact^1, 3 random table.
  always_comb begin
    case (mode)
      1:       mult_r = 8'd0;
      2:       mult_r = (8'(op_a) * 8'(op_b)) ^ 8'd1;
      3:       mult_r = lut[{op_a, op_b}];
      default: mult_r = 8'(op_a) * 8'(op_b);
    endcase
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int approx_ref(input int a, input int b);
    case (mode)
      1:       return 0;
      2:       return (a * b) ^ 1;
      3:       return int'(lut[a * 16 + b]);
      default: return a * b;
    endcase
  endfunction

  task automatic model(output longint cnt, output longint sum, output longint mx,
                       output longint bs);
    cnt = 0; sum = 0; mx = 0; bs = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        longint e = longint'(approx_ref(a, b)) - longint'(a * b);
        longint ae = (e < 0) ? -e : e;
        if (e != 0) cnt++;
        sum += ae;
        bs  += e;
        if (ae > mx) mx = ae;
      end
  endtask

  task automatic kick(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy_on"}, busy, 1);
    chk({tag, ".ops0"}, {op_a, op_b}, 0);
    chk({tag, ".cleared"}, err_cnt + sum_abs_err + max_abs_err, 0);
  endtask

  // Runs well past the end so the idle hold of the metrics is exercised too.
  task automatic wait_done(input bit glitch, output int cyc, output int pulses);
    cyc = 0;
    pulses = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      start = glitch && (i == 49 || i == 256);
      if (done) begin
        pulses++;
        if (cyc == 0) cyc = i;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_metrics(input string tag, input longint c, input longint s,
                               input longint m, input longint b);
    chk({tag, ".err_cnt"}, err_cnt, c);
    chk({tag, ".sum_abs"}, sum_abs_err, s);
    chk({tag, ".max_abs"}, max_abs_err, m);
    chk({tag, ".bias"}, longint'(bias), b);
  endtask

  task automatic full_run(input string tag, input bit glitch);
    int cyc, pulses;
    longint c, s, m, b;
    kick(tag);
    wait_done(glitch, cyc, pulses);
    chk({tag, ".done_cycle"}, cyc, 258);
    chk({tag, ".done_pulses"}, pulses, 1);
    chk({tag, ".busy_off"}, busy, 0);
    model(c, s, m, b);
    check_metrics(tag, c, s, m, b);
  endtask

  initial begin
    int cyc, pulses;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ops", {op_a, op_b}, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    check_metrics("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    mode = 0; full_run("exact", 1'b0);
    check_metrics("exact.k", 0, 0, 0, 0);
    mode = 1; full_run("zero", 1'b0);
    check_metrics("zero.k", 225, 14400, 225, -14400);
    mode = 2; full_run("xor1", 1'b0);
    check_metrics("xor1.k", 256, 256, 1, 128);
    mode = 3; full_run("lut_a", 1'b0);

    // Abort mid-sweep, then a clean rerun on a fresh random table.
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom_range(0, 255));
    kick("abort");
    repeat (99) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    wait_done(1'b0, cyc, pulses);
    chk("abort.no_done", pulses, 0);
    full_run("lut_b", 1'b0);

    // Start pulses at edges 50 and 257 must be ignored.
    mode = 2; full_run("glitch", 1'b1);

    // Start and abort together in IDLE: start wins.
    mode = 3;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    chk("both.busy", busy, 1);
    wait_done(1'b0, cyc, pulses);
    chk("both.done_cycle", cyc, 258);

    // Reset mid-sweep, then start on the first edge after release.
    kick("rstmid");
    repeat (119) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid.ops", {op_a, op_b}, 0);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    check_metrics("rstmid", 0, 0, 0, 0);
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("rstmid.no_done", pulses, 0);
    @(negedge clk);
    rst = 1'b0;
    full_run("after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/approx_mult_err_eval.md
APPROX_MULT_ERR_EVAL -- requirements
Module: approx_mult_err_eval

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width of the multiplier under test; legal range is 2..6.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: requests an exhaustive sweep; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels a sweep in progress.
REQ-006 The block SHALL have port op_a, output, N bits: registered multiplicand driven to the approximate multiplier A input.
REQ-007 The block SHALL have port op_b, output, N bits: registered multiplier driven to the approximate multiplier B input.
REQ-008 The block SHALL have port mult_r, input, 2N bits: combinational product returned by the multiplier under test.
REQ-009 The block SHALL have port busy, output, 1 bit: high in SWEEP and DRAIN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the metrics are final.
REQ-011 The block SHALL have port err_cnt, output, 2N+1 bits: number of pairs with mult_r != op_a*op_b.
REQ-012 The block SHALL have port sum_abs_err, output, 4N bits: sum of |mult_r - exact| over all pairs.
REQ-013 The block SHALL have port max_abs_err, output, 2N bits: largest |mult_r - exact| seen.
REQ-014 The block SHALL have port bias, output, 4N+1 bits signed: sum of (mult_r - exact) over all pairs.

Function
REQ-015 The block SHALL implement the FSM states IDLE, SWEEP, DRAIN and DONE.
REQ-016 When start is high in IDLE or DONE, the block SHALL move to SWEEP at that edge, set op_a=op_b=0 and clear all four metrics.
REQ-017 In SWEEP, each edge SHALL capture {mult_r, op_a*op_b} into stage 1 and advance the operands, with op_b as the inner index and op_a as the outer index.
REQ-018 When the operands wrap from (2^N-1, 2^N-1) to (0,0), the block SHALL enter DRAIN at that same edge.
REQ-019 Stage 2 SHALL register the signed difference, its absolute value and a nonzero flag.
REQ-020 Stage 3 SHALL accumulate all four metrics.
REQ-021 All accumulations SHALL be exact, with no saturation; the widths in REQ-011 to REQ-014 cannot overflow.
REQ-022 DRAIN SHALL last exactly 2 cycles and then go to DONE, so that the final accumulate and done=1 appear at edge 2^(2N)+2 after the start edge (258 for N=4).
REQ-023 DONE SHALL last 1 cycle and then go to IDLE.
REQ-024 The metrics SHALL hold their values in IDLE until the next accepted start.
REQ-025 When abort is high in SWEEP or DRAIN, the block SHALL go to IDLE at that edge, drop busy, squash the pipeline valids, leave done at 0 and leave the metrics as partial values that are not to be used.
REQ-026 Abort SHALL take priority over the SWEEP-to-DRAIN transition.
REQ-027 A start in SWEEP or DRAIN SHALL be ignored.
REQ-028 When start and abort are both high in IDLE, start SHALL win.
REQ-029 op_a and op_b SHALL be registered outputs, and mult_r SHALL be consumed only through the stage-1 register, with no other combinational path.

Reset
REQ-030 While rst is high, the block SHALL be in IDLE with op_a=0, op_b=0, busy=0, done=0, all metrics 0 and all pipeline valids 0.
REQ-031 A reset asserted mid-sweep SHALL give the same state as REQ-030, with no done pulse.
REQ-032 After rst deasserts, the block SHALL accept start on the first edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the width functions for N (product, count, sum and bias widths).
REQ-034 The metric datapath (stage 2 and stage 3) SHALL be one sub-module, err_accum, that is free of the FSM.
REQ-035 The FSM, the operand counter and stage 1 SHALL live in the top module.
REQ-036 The multiplier under test SHALL be instantiated outside this block.

Verification
REQ-037 With N=4 and mult_r = op_a*op_b exact, a start SHALL give, after 258 cycles, done with err_cnt=0, sum_abs_err=0, max_abs_err=0 and bias=0.
REQ-038 With N=4 and mult_r tied to 0, a start SHALL give err_cnt=225, sum_abs_err=14400, max_abs_err=225 and bias=-14400.
REQ-039 With N=4 and mult_r = exact XOR 1, a start SHALL give err_cnt=256, sum_abs_err=256, max_abs_err=1 and bias=+128.
REQ-040 With N=4, abort at cycle 100 of a sweep SHALL give busy=0 next cycle and no done; a following start SHALL give results identical to a clean run.
REQ-041 With N=4, a start pulsed at cycles 50 and 257 SHALL be ignored, with exactly one done at 258; rst asserted at cycle 120 SHALL give all outputs 0 immediately and no done.
REQ-042 With N=4 and the approximate 4x4 LUT/CARRY4 multiplier connected, a full sweep SHALL give metrics that match a software golden model computed over all 256 pairs.
